// File: rtl/channel_mux_reg.sv
// channel_mux_reg: a registered N:1 stream multiplexer.
//
// It selects one of CHANNELS valid/ready input streams and passes the word into a
// single-entry output register. The channel is chosen either by explicit address or by
// a round-robin arbiter over the valid inputs.
//
// Build option: define MUX_RR_EN to build the round-robin mode and its rotating pointer.
// Without it, mode_i is ignored and the block always works in address mode.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_ni       synchronous active-low reset
//   mode_i         0 = address select, 1 = round-robin (MUX_RR_EN only)
//   address_i      selected channel in address mode
//   in_data_i      channel k is bits [k*WIDTH +: WIDTH]
//   in_valid_i     per-channel valid
//   in_ready_o     per-channel ready; at most one bit is high
//   out_data_o     registered output word
//   out_channel_o  index of the channel that supplied out_data_o
//   out_valid_o    the output register holds a word
//   out_ready_i    the consumer accepts the word
//   addr_err_o     sticky flag: an out-of-range address was seen in address mode
module channel_mux_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          address_i,
    input  logic [CHANNELS*WIDTH-1:0] in_data_i,
    input  logic [CHANNELS-1:0]       in_valid_i,
    output logic [CHANNELS-1:0]       in_ready_o,
    output logic [WIDTH-1:0]          out_data_o,
    output logic [SEL_W-1:0]          out_channel_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      addr_err_o
);

    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_channel_q;
    logic             out_valid_q;
    logic             addr_err_q;

    logic             rr_mode;
    logic             addr_bad;
    logic             can_load;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] rr_ptr_d;

    assign rr_mode = mode_i;
`else
    logic unused_mode;

    assign rr_mode     = 1'b0;
    assign unused_mode = mode_i;
`endif

    assign addr_bad = !rr_mode && (32'(address_i) >= CHANNELS);
    // A full register can still take a new word when the consumer pops it this cycle.
    assign can_load = !out_valid_q || out_ready_i;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifdef MUX_RR_EN
        if (rr_mode) begin
            // Scan from rr_ptr upwards with wrap; the first valid channel wins.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                int unsigned idx;
                idx = 32'(rr_ptr_q) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!gnt_vld && in_valid_i[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(idx);
                end
            end
        end else
`endif
        if (!addr_bad && in_valid_i[address_i]) begin
            gnt_vld = 1'b1;
            gnt_idx = address_i;
        end
    end

    // Reset is part of the qualifier so that no channel sees ready while reset is held.
    assign xfer = reset_ni && gnt_vld && can_load;

    always_comb begin
        in_ready_o = '0;
        if (xfer) in_ready_o[gnt_idx] = 1'b1;
    end

`ifdef MUX_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && rr_mode) begin
            rr_ptr_d = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) rr_ptr_q <= '0;
        else           rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            if (xfer) begin
                out_data_q    <= in_data_i[gnt_idx*WIDTH +: WIDTH];
                out_channel_q <= gnt_idx;
                out_valid_q   <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q   <= 1'b0;
            end
            if (addr_bad) addr_err_q <= 1'b1;
        end
    end

    assign out_data_o    = out_data_q;
    assign out_channel_o = out_channel_q;
    assign out_valid_o   = out_valid_q;
    assign addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_channel_mux_reg.sv
// Testbench for channel_mux_reg: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model. A second, 3-channel instance exercises
// the out-of-range address flag.
module tb_channel_mux_reg;

`ifdef MUX_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  address;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        addr_err;

    logic        rst3_n;
    logic [1:0]  address3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_channel3;
    logic        out_valid3;
    logic        addr_err3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    logic       m_err;

    always #5 clk = ~clk;

    channel_mux_reg #(.WIDTH(8), .CHANNELS(4)) u_dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .mode_i       (mode),
        .address_i    (address),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_data_o   (out_data),
        .out_channel_o(out_channel),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .addr_err_o   (addr_err)
    );

    channel_mux_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk_i        (clk),
        .reset_ni     (rst3_n),
        .mode_i       (1'b0),
        .address_i    (address3),
        .in_data_i    (in_data3),
        .in_valid_i   (in_valid3),
        .in_ready_o   (in_ready3),
        .out_data_o   (out_data3),
        .out_channel_o(out_channel3),
        .out_valid_o  (out_valid3),
        .out_ready_i  (1'b1),
        .addr_err_o   (addr_err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel the model would grant this cycle, or -1 for none.
    function automatic int model_grant();
        if (RrEn && mode) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (in_valid[k]) return k;
            end
            return -1;
        end
        if (in_valid[address]) return int'(address);
        return -1;
    endfunction

    // One clock cycle with the inputs already driven: check ready, advance model, check outputs.
    task automatic step();
        int g;
        logic xfer;
        logic [3:0] exp_ready;
        #1;
        g = model_grant();
        xfer = rst_n && (g >= 0) && (!m_valid || out_ready);
        exp_ready = xfer ? (4'b0001 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 0;
            m_ptr   = 0;
            m_err   = 1'b0;
        end else if (xfer) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (RrEn && mode) m_ptr = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("addr_err", 32'(addr_err), 32'(m_err));
        if (m_valid || !rst_n) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_channel", 32'(out_channel), 32'(m_ch));
        end
    endtask

    task automatic set_ch(input int k, input logic [7:0] d);
        in_data[k*8 +: 8] = d;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; address = 2'd0;
        in_data = 32'h0; in_valid = 4'b1111; out_ready = 1'b1;
        rst3_n = 1'b0; address3 = 2'd0; in_data3 = 24'h0; in_valid3 = 3'b000;
        m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0; m_err = 1'b0;
        @(negedge clk);

        // Reset held for two cycles with every channel valid.
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);

        // Address mode picks channel 2.
        rst_n = 1'b1;
        address = 2'd2;
        in_data = 32'h33A5_2211;
        #1 check("addr_ready_0100", 32'(in_ready), 32'h4);
        step();
        check("addr_data_a5", 32'(out_data), 32'hA5);
        check("addr_ch_2", 32'(out_channel), 32'h2);

        // Backpressure: hold 0x11 while ch1 waits with 0x22.
        address = 2'd1;
        in_valid = 4'b0010;
        set_ch(1, 8'h11);
        step();
        check("bp_load_11", 32'(out_data), 32'h11);
        out_ready = 1'b0;
        set_ch(1, 8'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_11", 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'h2);
        step();
        check("bp_load_22", 32'(out_data), 32'h22);
        in_valid = 4'b0000;
        step();
        check("bp_drained", 32'(out_valid), 32'h0);

        if (RrEn) begin
            // Full rotation, then only ch1/ch3, then the wrap case from pointer 3.
            mode = 1'b1;
            in_valid = 4'b1111;
            for (int i = 0; i < 5; i++) begin
                step();
                check("rr_all_seq", 32'(out_channel), 32'(i % 4));
            end
            in_valid = 4'b1010;
            for (int i = 0; i < 4; i++) begin
                step();
                check("rr_odd_seq", 32'(out_channel), (i % 2 == 0) ? 32'd1 : 32'd3);
            end
            in_valid = 4'b0100;
            step();
            in_valid = 4'b0001;
            step();
            check("rr_wrap_ch0", 32'(out_channel), 32'h0);
            in_valid = 4'b1111;
            step();
            check("rr_ptr_now_1", 32'(out_channel), 32'h1);
            mode = 1'b0;
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            mode      = 1'($urandom);
            address   = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1'b1;

        // Three-channel instance: address 3 is out of range.
        rst3_n = 1'b1;
        in_valid3 = 3'b111;
        in_data3 = 24'hC0B0A0;
        address3 = 2'd3;
        #1 check("c3_bad_ready", 32'(in_ready3), 32'h0);
        @(negedge clk);
        check("c3_err_set", 32'(addr_err3), 32'h1);
        check("c3_no_load", 32'(out_valid3), 32'h0);
        address3 = 2'd0;
        #1 check("c3_ok_ready", 32'(in_ready3), 32'h1);
        @(negedge clk);
        check("c3_err_sticky", 32'(addr_err3), 32'h1);
        check("c3_data_a0", 32'(out_data3), 32'hA0);
        rst3_n = 1'b0;
        @(negedge clk);
        check("c3_err_cleared", 32'(addr_err3), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_mux_reg.md
# channel_mux_reg

Parametrised, registered successor to the 4:1 multiplexer: selects one of CHANNELS input streams of WIDTH bits and presents it through a single-entry output register with valid/ready handshaking on every channel and on the output. Channel selection is either by explicit address or by a round-robin arbiter over the valid inputs. It sits between multiple producer streams and one shared consumer.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), address and channel-tag width; derived, do not override
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset; sampled on rising clk
- mode  input  1  0 = address select, 1 = round-robin (see Configuration)
- address  input  SEL_W  selected channel in address mode
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit high
- out_data  output  WIDTH  registered data
- out_channel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- addr_err  output  1  sticky: address ≥ CHANNELS was presented in address mode

## Operation
- Output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = EMPTY, or FULL with out_ready=1 (pop and load in the same cycle).
- Grant, address mode: grant = address if address < CHANNELS and in_valid[address]=1; otherwise no grant.
- Grant, round-robin mode: scan channels starting at pointer rr_ptr, wrapping past CHANNELS-1 to 0; grant = first k with in_valid[k]=1; no grant if in_valid is all zero.
- in_ready[grant] = can_load; all other in_ready bits 0. in_ready is combinational from in_valid, mode, address, rr_ptr, out_valid, out_ready; it never depends on in_data.
- Transfer on a channel occurs when in_valid[k] & in_ready[k] at a rising edge: out_data ← in_data slice k, out_channel ← k, state → FULL.
- FULL with out_ready=1 and no transfer → EMPTY. FULL with out_ready=0 → hold out_data/out_channel unchanged.
- rr_ptr updates only on a round-robin transfer: rr_ptr ← (grant+1) wrapping CHANNELS-1 → 0. Address-mode transfers leave rr_ptr unchanged.
- addr_err sets when mode=0 and address ≥ CHANNELS (possible only when CHANNELS is not a power of 2); cleared only by reset.
- mode and address may change on any cycle; they take effect for the grant in that same cycle. A held word is never affected by a later mode/address change.

## Timing
- Reset (reset_n=0 at edge): out_valid=0, out_data=0, out_channel=0, rr_ptr=0, addr_err=0. With reset held, all in_ready=0. Reset mid-transfer discards the held word.
- Latency: input transfer at edge n → out_valid=1 with that data after edge n.
- Throughput: one word per cycle while out_ready=1 and a grant exists.
- No combinational path from in_data to out_data; out_ready → in_ready is combinational (one-level pass-through).

## Configuration
- MUX_RR_EN defined: round-robin mode and rr_ptr are built in; mode behaves as above.
- MUX_RR_EN undefined: no rr_ptr logic; mode is ignored and the block always operates in address mode; addr_err still operates with mode treated as 0.

## Test plan
- Reset: drive reset_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, in_ready=0, addr_err=0; release → first transfer next edge.
- Address mode, CHANNELS=4, WIDTH=8: address=2, in_data ch2=0xA5, in_valid=4'b1111, out_ready=1 → in_ready=4'b0100, one cycle later out_data=0xA5, out_channel=2.
- Backpressure: FULL with 0x11, out_ready=0 for 3 cycles, ch1 valid 0x22 → in_ready=0, out_data holds 0x11; raise out_ready → 0x22 loaded that edge, no word lost or duplicated.
- Round-robin (MUX_RR_EN): all 4 channels valid continuously, out_ready=1 → out_channel sequence 0,1,2,3,0; with only ch1 and ch3 valid → 1,3,1,3.
- Round-robin wrap: rr_ptr=3, only ch0 valid → grant ch0, rr_ptr becomes 1.
- CHANNELS=3, address=3, in_valid=3'b111 → in_ready=0, addr_err=1 and stays 1 after address returns to 0; cleared only by reset.
